// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Shares the single register-file write port between the ALU and LSU writeback
// sources. Round-robin on conflicts, one registered write per cycle, writes to
// x0 are accepted but never reach the port.
//
// Ports:
//   clk, reset                      rising-edge clock, synchronous active-high reset
//   alu_wb_valid/rd/data, *_ready   ALU writeback handshake (ready is combinational)
//   lsu_wb_valid/rd/data, *_ready   LSU writeback handshake (ready is combinational)
//   reg_write_en, rd, write_data    registered register-file write port
//   conflict_cnt                    saturating count of cycles with two real requests
module wb_port_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_wb_valid,
    input  logic [ADDR_W-1:0] alu_wb_rd,
    input  logic [DATA_W-1:0] alu_wb_data,
    output logic              alu_wb_ready,
    input  logic              lsu_wb_valid,
    input  logic [ADDR_W-1:0] lsu_wb_rd,
    input  logic [DATA_W-1:0] lsu_wb_data,
    output logic              lsu_wb_ready,
    output logic              reg_write_en,
    output logic [ADDR_W-1:0] rd,
    output logic [DATA_W-1:0] write_data,
    output logic [CNT_W-1:0]  conflict_cnt
);

    logic              r_last_grant;  // 0 = ALU, 1 = LSU
    logic              r_write_en;
    logic [ADDR_W-1:0] r_rd;
    logic [DATA_W-1:0] r_data;
    logic [CNT_W-1:0]  r_cnt;

    logic w_alu_real, w_alu_null;
    logic w_lsu_real, w_lsu_null;
    logic w_both;
    logic w_grant_alu, w_grant_lsu;

    always_comb begin
        w_alu_real  = alu_wb_valid && (alu_wb_rd != '0);
        w_alu_null  = alu_wb_valid && (alu_wb_rd == '0);
        w_lsu_real  = lsu_wb_valid && (lsu_wb_rd != '0);
        w_lsu_null  = lsu_wb_valid && (lsu_wb_rd == '0);
        w_both      = w_alu_real && w_lsu_real;
        // On a tie the source that did not win last time gets the port.
        w_grant_alu = w_both ? r_last_grant  : w_alu_real;
        w_grant_lsu = w_both ? !r_last_grant : w_lsu_real;
    end

    // Null requests are absorbed immediately; nothing is accepted during reset.
    assign alu_wb_ready = !reset && (w_alu_null || w_grant_alu);
    assign lsu_wb_ready = !reset && (w_lsu_null || w_grant_lsu);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= 1'b1;
            r_write_en   <= 1'b0;
            r_rd         <= '0;
            r_data       <= '0;
            r_cnt        <= '0;
        end else begin
            r_write_en <= w_grant_alu || w_grant_lsu;
            if (w_grant_alu) begin
                r_rd         <= alu_wb_rd;
                r_data       <= alu_wb_data;
                r_last_grant <= 1'b0;
            end else if (w_grant_lsu) begin
                r_rd         <= lsu_wb_rd;
                r_data       <= lsu_wb_data;
                r_last_grant <= 1'b1;
            end
            if (w_both && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign reg_write_en = r_write_en;
    assign rd           = r_rd;
    assign write_data   = r_data;
    assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_wb_valid, lsu_wb_valid;
    logic [4:0]  alu_wb_rd, lsu_wb_rd;
    logic [31:0] alu_wb_data, lsu_wb_data;
    logic        alu_wb_ready, lsu_wb_ready;
    logic        reg_write_en;
    logic [4:0]  rd;
    logic [31:0] write_data;
    logic [15:0] conflict_cnt;

    // Second instance with a 2-bit counter for the saturation check.
    logic        reset2;
    logic        v2;
    logic        a2_ready, l2_ready, we2;
    logic [4:0]  rd2;
    logic [31:0] wd2;
    logic [1:0]  cnt2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    wb_port_arbiter #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .alu_wb_valid (alu_wb_valid),
        .alu_wb_rd    (alu_wb_rd),
        .alu_wb_data  (alu_wb_data),
        .alu_wb_ready (alu_wb_ready),
        .lsu_wb_valid (lsu_wb_valid),
        .lsu_wb_rd    (lsu_wb_rd),
        .lsu_wb_data  (lsu_wb_data),
        .lsu_wb_ready (lsu_wb_ready),
        .reg_write_en (reg_write_en),
        .rd           (rd),
        .write_data   (write_data),
        .conflict_cnt (conflict_cnt)
    );

    wb_port_arbiter #(.DATA_W(32), .ADDR_W(5), .CNT_W(2)) u_dut2 (
        .clk          (clk),
        .reset        (reset2),
        .alu_wb_valid (v2),
        .alu_wb_rd    (5'd1),
        .alu_wb_data  (32'h1),
        .alu_wb_ready (a2_ready),
        .lsu_wb_valid (v2),
        .lsu_wb_rd    (5'd2),
        .lsu_wb_data  (32'h2),
        .lsu_wb_ready (l2_ready),
        .reg_write_en (we2),
        .rd           (rd2),
        .write_data   (wd2),
        .conflict_cnt (cnt2)
    );

    typedef struct {
        int          cyc;
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    typedef struct {
        logic        rst;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adat;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldat;
        logic        exp_ar;
        logic        exp_lr;
        logic [15:0] exp_cnt;  // counter value visible during this cycle
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic av, input logic [4:0] ard,
                                input logic [31:0] adat, input logic lv,
                                input logic [4:0] lrd, input logic [31:0] ldat,
                                input logic ear, input logic elr, input logic [15:0] ecnt);
        vec_t v;
        v.rst = rst; v.av = av; v.ard = ard; v.adat = adat;
        v.lv = lv; v.lrd = lrd; v.ldat = ldat;
        v.exp_ar = ear; v.exp_lr = elr; v.exp_cnt = ecnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every port write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reg_write_en === 1'b1) begin
            wr_t e;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: got rd=%0d data=%0h expected no write (cycle %0d)",
                         rd, write_data, cyc);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.rd !== rd || e.data !== write_data) begin
                    bad++;
                    $display("FAIL port_write: got cyc=%0d rd=%0d data=%0h expected cyc=%0d rd=%0d data=%0h",
                             cyc, rd, write_data, e.cyc, e.rd, e.data);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        reset2 = 1'b1;
        v2 = 1'b0;
        alu_wb_valid = 1'b0; alu_wb_rd = '0; alu_wb_data = '0;
        lsu_wb_valid = 1'b0; lsu_wb_rd = '0; lsu_wb_data = '0;

        // Single ALU write, latency 1, then idle.
        vecs.push_back(mk(0, 1, 3, 32'hA5A5_0001, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Reset, then a tie: ALU first, LSU next cycle.
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 32'h11, 1, 2, 32'h22, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 2, 32'h22, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        // Reset, then six cycles of continuous contention.
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 10, 32'hA0, 1, 20, 32'hB0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 11, 32'hA1, 1, 20, 32'hB0, 0, 1, 1));
        vecs.push_back(mk(0, 1, 11, 32'hA1, 1, 21, 32'hB1, 1, 0, 2));
        vecs.push_back(mk(0, 1, 12, 32'hA2, 1, 21, 32'hB1, 0, 1, 3));
        vecs.push_back(mk(0, 1, 12, 32'hA2, 1, 22, 32'hB2, 1, 0, 4));
        vecs.push_back(mk(0, 1, 13, 32'hA3, 1, 22, 32'hB2, 0, 1, 5));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 6));
        // ALU x0 write alongside real LSU write: both ready, only LSU written.
        vecs.push_back(mk(0, 1, 0, 32'hFFFF_FFFF, 1, 7, 32'h77, 1, 1, 6));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 6));
        // last_grant is LSU, so ALU wins this tie.
        vecs.push_back(mk(0, 1, 1, 32'h1111, 1, 2, 32'h2222, 1, 0, 6));
        vecs.push_back(mk(0, 0, 0, 0, 1, 2, 32'h2222, 0, 1, 7));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 7));
        // Reset in the same cycle as an ALU request: refused, then accepted after.
        vecs.push_back(mk(1, 1, 4, 32'h44, 0, 0, 0, 0, 0, 7));
        vecs.push_back(mk(0, 1, 4, 32'h44, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_we", {31'b0, reg_write_en}, 32'h0);
        check("reset_rd", {27'b0, rd}, 32'h0);
        check("reset_data", write_data, 32'h0);
        check("reset_cnt", {16'b0, conflict_cnt}, 32'h0);

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            reset = vecs[i].rst;
            alu_wb_valid = vecs[i].av; alu_wb_rd = vecs[i].ard; alu_wb_data = vecs[i].adat;
            lsu_wb_valid = vecs[i].lv; lsu_wb_rd = vecs[i].lrd; lsu_wb_data = vecs[i].ldat;
            @(negedge clk);
            check($sformatf("alu_ready[%0d]", i), {31'b0, alu_wb_ready}, {31'b0, vecs[i].exp_ar});
            check($sformatf("lsu_ready[%0d]", i), {31'b0, lsu_wb_ready}, {31'b0, vecs[i].exp_lr});
            check($sformatf("cnt[%0d]", i), {16'b0, conflict_cnt}, {16'b0, vecs[i].exp_cnt});
            if (vecs[i].exp_ar && vecs[i].ard != 0)
                exp_q.push_back('{cyc + 1, vecs[i].ard, vecs[i].adat});
            if (vecs[i].exp_lr && vecs[i].lrd != 0)
                exp_q.push_back('{cyc + 1, vecs[i].lrd, vecs[i].ldat});
        end

        // Saturating 2-bit counter: 1,2,3,3,3.
        @(posedge clk);
        #1;
        reset2 = 1'b0;
        v2 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            logic [1:0] exp_c;
            exp_c = (k < 3) ? 2'(k + 1) : 2'd3;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("sat_cnt[%0d]", k), {30'b0, cnt2}, {30'b0, exp_c});
        end
        v2 = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port (reg_write_en / rd / write_data) between two writeback sources: ALU and load/store unit (LSU).
- Each source uses a valid/ready handshake.
- Round-robin arbitration on conflicts, one registered write per cycle, x0 writes absorbed without using the port.
- Sits between execute/memory stages and the register file; also exposes a saturating conflict counter for performance monitoring.

Parameters:
- DATA_W, 32, write data width
- ADDR_W, 5, register index width
- CNT_W, 16, conflict counter width

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- alu_wb_valid  input  1  ALU has a writeback pending
- alu_wb_rd  input  ADDR_W  ALU destination register
- alu_wb_data  input  DATA_W  ALU result
- alu_wb_ready  output  1  ALU request accepted this cycle (combinational)
- lsu_wb_valid  input  1  LSU has a writeback pending
- lsu_wb_rd  input  ADDR_W  LSU destination register
- lsu_wb_data  input  DATA_W  load data
- lsu_wb_ready  output  1  LSU request accepted this cycle (combinational)
- reg_write_en  output  1  register-file write enable (registered)
- rd  output  ADDR_W  register-file write index (registered)
- write_data  output  DATA_W  register-file write data (registered)
- conflict_cnt  output  CNT_W  cycles with both sources valid with nonzero rd, saturating

Behaviour:
- Transfer occurs on a rising edge where valid && ready. A source must hold valid, rd and data stable until accepted. ready may depend on valid; valid must not depend on ready.
- "Real" request: valid && rd != 0. "Null" request: valid && rd == 0.
- Null requests:
  - ready = 1 in the same cycle, regardless of the other source.
  - Never drive the write port; do not affect last_grant or conflict_cnt.
- Real requests, one source only: that source is granted.
- Real requests, both sources:
  - Grant the source not in last_grant; the other sees ready = 0.
  - conflict_cnt increments by 1, saturating at all-ones (no wrap).
- last_grant: 1 bit (0 = ALU, 1 = LSU). Updated to the granted source on every real grant; otherwise holds.
- Output timing:
  - A granted real request appears on reg_write_en/rd/write_data at the next rising edge, valid for exactly one cycle (latency 1).
  - With no real grant, reg_write_en = 0 the following cycle.
  - rd/write_data hold their previous values when reg_write_en = 0.
- Throughput: one real write per cycle. Back-to-back grants to the same source are allowed when the other source is idle.
- Reset (synchronous, active-high):
  - Registered outputs: reg_write_en = 0, rd = 0, write_data = 0.
  - conflict_cnt = 0.
  - last_grant = 1, so ALU wins the first tie.
  - While reset = 1, alu_wb_ready = lsu_wb_ready = 0; nothing is accepted.
- Reset mid-operation: a grant in the reset cycle is discarded. The source still sees ready = 0 and must re-present after reset; no write issues in the cycle after reset.
- Simultaneous real and null requests (e.g. ALU rd = 0, LSU rd = 5): both ready = 1 the same cycle. Only the LSU write reaches the port. Not a conflict.
- Same rd from both sources: no ordering by rd. Round-robin order alone decides. Upstream guarantees program order if required.

Test Plan:
- Reset, then ALU valid rd=3 data=0xA5A5_0001 alone -> alu_wb_ready=1 same cycle; next cycle reg_write_en=1, rd=3, write_data=0xA5A5_0001; following cycle reg_write_en=0.
- Both valid after reset (ALU rd=1 data=0x11, LSU rd=2 data=0x22), held until accepted -> cycle 0 ALU granted, cycle 1 LSU granted; port shows rd=1 then rd=2 on consecutive cycles; conflict_cnt=1 (second cycle has LSU only).
- Both sources continuously valid with nonzero rd for 6 cycles -> grants alternate ALU,LSU,ALU,LSU,ALU,LSU; reg_write_en=1 every cycle from cycle 1; conflict_cnt=6.
- ALU rd=0 data=0xFFFF_FFFF with LSU rd=7 data=0x77 -> both ready=1 same cycle; next cycle rd=7, write_data=0x77; no write to index 0 ever; conflict_cnt unchanged; last_grant=LSU.
- CNT_W=2, force 5 conflict cycles -> conflict_cnt reads 1,2,3,3,3 (saturates at 3).
- Assert reset in the same cycle as ALU valid rd=4 -> alu_wb_ready=0; reg_write_en=0 the next cycle; after reset release, ALU request accepted and written normally.
